// File: rtl/bist_response_analyzer.sv
// MISR-based response analyzer for a BIST controller: compacts captured CUT words
// into a signature and compares signature and capture count against golden values.
module bist_response_analyzer #(
  parameter int                DATA_W       = 8,
  parameter int                SIG_W        = 16,
  parameter logic [SIG_W-1:0]  POLY         = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED         = 16'h0000,
  parameter logic [SIG_W-1:0]  GOLDEN       = 16'h0000,
  parameter int                EXP_CAPTURES = 81
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RUNNING,
  input  logic              OUT,
  input  logic              BIST_END,
  input  logic [DATA_W-1:0] CUT_DATA,
  output logic [SIG_W-1:0]  SIGNATURE,
  output logic [7:0]        CAPTURE_CNT,
  output logic              DONE,
  output logic              PASS,
  output logic              FAIL
);

  localparam logic [7:0] EXP_CNT = 8'(EXP_CAPTURES);

  typedef enum logic [1:0] {IDLE, COMPACT, CHECK, REPORT} state_t;

  state_t           state;
  logic [SIG_W-1:0] sig_next;
  logic             match;

  // One MISR step: shift, fold the dropped MSB back through the polynomial, mix in data.
  always_comb begin
    sig_next = {SIGNATURE[SIG_W-2:0], 1'b0}
             ^ (SIGNATURE[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(CUT_DATA);
  end

  assign match = (SIGNATURE == GOLDEN) && (CAPTURE_CNT == EXP_CNT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      SIGNATURE   <= SEED;
      CAPTURE_CNT <= 8'd0;
      DONE        <= 1'b0;
      PASS        <= 1'b0;
      FAIL        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (RUNNING) begin
            SIGNATURE   <= SEED;
            CAPTURE_CNT <= 8'd0;
            state       <= COMPACT;
          end
        end
        COMPACT: begin
          // End of test wins over a coincident capture strobe.
          if (BIST_END) begin
            state <= CHECK;
          end else if (RUNNING && OUT) begin
            SIGNATURE <= sig_next;
            if (CAPTURE_CNT != 8'hFF) begin
              CAPTURE_CNT <= CAPTURE_CNT + 8'd1;
            end
          end
        end
        CHECK: begin
          DONE  <= 1'b1;
          PASS  <= match;
          FAIL  <= !match;
          state <= REPORT;
        end
        REPORT: begin
          if (RUNNING) begin
            DONE        <= 1'b0;
            PASS        <= 1'b0;
            FAIL        <= 1'b0;
            SIGNATURE   <= SEED;
            CAPTURE_CNT <= 8'd0;
            state       <= COMPACT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: a default instance and one with GOLDEN=3, EXP_CAPTURES=2,
// both fed the same stimulus and checked against a queue-based reference model.
module tb_bist_response_analyzer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        RUNNING = 1'b0;
  logic        OUT = 1'b0;
  logic        BIST_END = 1'b0;
  logic [7:0]  CUT_DATA = 8'h00;

  logic [15:0] sig_a, sig_b;
  logic [7:0]  cnt_a, cnt_b;
  logic        done_a, done_b, pass_a, pass_b, fail_a, fail_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bist_response_analyzer dut_a (
    .CLK(CLK), .RESET(RESET), .RUNNING(RUNNING), .OUT(OUT), .BIST_END(BIST_END),
    .CUT_DATA(CUT_DATA), .SIGNATURE(sig_a), .CAPTURE_CNT(cnt_a),
    .DONE(done_a), .PASS(pass_a), .FAIL(fail_a)
  );

  bist_response_analyzer #(.GOLDEN(16'h0003), .EXP_CAPTURES(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .RUNNING(RUNNING), .OUT(OUT), .BIST_END(BIST_END),
    .CUT_DATA(CUT_DATA), .SIGNATURE(sig_b), .CAPTURE_CNT(cnt_b),
    .DONE(done_b), .PASS(pass_b), .FAIL(fail_b)
  );

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_COLLECT, P_CHECK, P_REPORT} phase_t;
  phase_t phase = P_IDLE;
  int     words[$];
  int     golden[2] = '{0, 3};
  int     expc[2]   = '{81, 2};
  logic   m_done = 1'b0;
  logic   m_pass[2] = '{1'b0, 1'b0};
  logic   m_fail[2] = '{1'b0, 1'b0};

  // Multiply by x in GF(2)[x] modulo x^16 + 0x1021.
  function automatic int mul_x(input int s);
    int t;
    t = s * 2;
    if (t >= 65536) t = (t - 65536) ^ 32'h1021;
    return t;
  endfunction

  function automatic int sig_of();
    int s;
    s = 0;
    foreach (words[i]) s = mul_x(s) ^ words[i];
    return s;
  endfunction

  function automatic int cnt_of();
    return (words.size() > 255) ? 255 : words.size();
  endfunction

  task automatic model_reset();
    phase  = P_IDLE;
    words.delete();
    m_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pass[i] = 1'b0;
      m_fail[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    case (phase)
      P_IDLE: if (RUNNING) begin words.delete(); phase = P_COLLECT; end
      P_COLLECT: begin
        if (BIST_END) phase = P_CHECK;
        else if (RUNNING && OUT) words.push_back(int'(CUT_DATA));
      end
      P_CHECK: begin
        m_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
          m_pass[i] = (sig_of() == golden[i]) && (cnt_of() == expc[i]);
          m_fail[i] = !m_pass[i];
        end
        phase = P_REPORT;
      end
      P_REPORT: begin
        if (RUNNING) begin
          m_done = 1'b0;
          for (int i = 0; i < 2; i++) begin
            m_pass[i] = 1'b0;
            m_fail[i] = 1'b0;
          end
          words.delete();
          phase = P_COLLECT;
        end
      end
      default: phase = P_IDLE;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("a.sig",  32'(sig_a),  32'(sig_of()));
    chk("a.cnt",  32'(cnt_a),  32'(cnt_of()));
    chk("a.done", 32'(done_a), 32'(m_done));
    chk("a.pass", 32'(pass_a), 32'(m_pass[0]));
    chk("a.fail", 32'(fail_a), 32'(m_fail[0]));
    chk("b.sig",  32'(sig_b),  32'(sig_of()));
    chk("b.cnt",  32'(cnt_b),  32'(cnt_of()));
    chk("b.done", 32'(done_b), 32'(m_done));
    chk("b.pass", 32'(pass_b), 32'(m_pass[1]));
    chk("b.fail", 32'(fail_b), 32'(m_fail[1]));
    chk("a.excl", 32'(pass_a & fail_a), 32'd0);
  endtask

  // Drive at the falling edge, let the rising edge act, check 1 time unit later.
  task automatic step(input logic r, input logic o, input logic b, input logic [7:0] d);
    RUNNING = r; OUT = o; BIST_END = b; CUT_DATA = d;
    @(posedge CLK);
    model_edge();
    #1;
    check_model();
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("rst.sig", 32'(sig_a), 32'h0);
    chk("rst.cnt", 32'(cnt_a), 32'h0);
    RUNNING = 1'b0; OUT = 1'b0; BIST_END = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  typedef struct {
    int          reps;
    logic        r, o, b;
    logic [7:0]  d;
    logic [15:0] sig;
    logic [7:0]  cnt;
    logic        done, pass, fail;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1,  1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{1,  1'b1, 1'b1, 1'b0, 8'h01, 16'h0001, 8'd1,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{15, 1'b1, 1'b1, 1'b0, 8'h00, 16'h8000, 8'd16, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1,  1'b1, 1'b1, 1'b0, 8'h00, 16'h1021, 8'd17, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2,  1'b1, 1'b0, 1'b0, 8'h5A, 16'h1021, 8'd17, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2,  1'b0, 1'b1, 1'b0, 8'hA5, 16'h1021, 8'd17, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1,  1'b1, 1'b1, 1'b1, 8'hFF, 16'h1021, 8'd17, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 16'h1021, 8'd17, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{3,  1'b0, 1'b1, 1'b1, 8'h33, 16'h1021, 8'd17, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1,  1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0,  1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    check_model();
    chk("reset.done", 32'(done_a), 32'd0);
    RESET = 1'b1;
    $display("reset released");

    // Table-driven vectors: feedback path, holds, BIST_END priority, REPORT hold, restart
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].r, tbl[i].o, tbl[i].b, tbl[i].d);
      chk($sformatf("vec%0d.sig", i),  32'(sig_a),  32'(tbl[i].sig));
      chk($sformatf("vec%0d.cnt", i),  32'(cnt_a),  32'(tbl[i].cnt));
      chk($sformatf("vec%0d.done", i), 32'(done_a), 32'(tbl[i].done));
      chk($sformatf("vec%0d.pass", i), 32'(pass_a), 32'(tbl[i].pass));
      chk($sformatf("vec%0d.fail", i), 32'(fail_a), 32'(tbl[i].fail));
      $display("vector %0d: sig=%h cnt=%0d done=%b pass=%b fail=%b", i, sig_a, cnt_a, done_a, pass_a, fail_a);
    end

    // Scenario 1: 81 zero captures pass; DONE appears exactly two edges after BIST_END
    repeat (81) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("s1.done_early", 32'(done_a), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s1.sig",  32'(sig_a),  32'h0000);
    chk("s1.cnt",  32'(cnt_a),  32'd81);
    chk("s1.done", 32'(done_a), 32'd1);
    chk("s1.pass", 32'(pass_a), 32'd1);
    chk("s1.fail", 32'(fail_a), 32'd0);
    $display("scenario 1: cnt=%0d pass=%b", cnt_a, pass_a);

    // Scenario 6: REPORT holds for 10 idle cycles, then restart clears
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'hFF);
      chk("s6.hold_cnt",  32'(cnt_a),  32'd81);
      chk("s6.hold_pass", 32'(pass_a), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("s6.done", 32'(done_a), 32'd0);
    chk("s6.cnt",  32'(cnt_a),  32'd0);
    $display("scenario 6: restart done=%b cnt=%0d", done_a, cnt_a);

    // Scenario 2: second instance expects two captures with signature 3
    step(1'b1, 1'b1, 1'b0, 8'h01);
    chk("s2.sig1", 32'(sig_b), 32'h0001);
    step(1'b1, 1'b1, 1'b0, 8'h01);
    chk("s2.sig2", 32'(sig_b), 32'h0003);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s2.pass_b", 32'(pass_b), 32'd1);
    chk("s2.fail_a", 32'(fail_a), 32'd1);
    $display("scenario 2: sig_b=%h pass_b=%b", sig_b, pass_b);

    // Scenario 4: 80 captures fail; coincident OUT and BIST_END does not capture
    step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (80) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    chk("s4.cnt_end", 32'(cnt_a), 32'd80);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s4.fail", 32'(fail_a), 32'd1);
    chk("s4.pass", 32'(pass_a), 32'd0);
    $display("scenario 4: cnt=%0d fail=%b", cnt_a, fail_a);

    // Scenario 5: reset mid-test discards the partial result
    step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (40) step(1'b1, 1'b1, 1'b0, 8'h00);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("s5.idle_cnt", 32'(cnt_a), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (81) step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s5.pass", 32'(pass_a), 32'd1);
    $display("scenario 5: pass=%b", pass_a);

    // Counter saturation with random data
    step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (300) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    chk("sat.cnt", 32'(cnt_a), 32'd255);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sat.fail", 32'(fail_a), 32'd1);
    $display("saturation: cnt=%0d", cnt_a);

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0), 8'($urandom));
    end
    $display("random: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
